// File: rtl/rho_rotator_seq_if.sv
// Handshake bundle for the sequential rho engine: input state with valid/ready,
// output state with valid/ready, completion pulse and FSM state for observation.
interface rho_rotator_seq_if #(
    parameter int W = 64
) ();
    // valid/ready: a transfer happens on a rising clk edge where both are 1;
    // the producer holds valid and its payload steady until that edge, and the
    // payload is ignored while valid is 0.
    logic [25*W-1:0] in_state;
    logic            in_valid;
    logic            in_ready;
    logic            inverse;
    logic [25*W-1:0] out_state;
    logic            out_valid;
    logic            out_ready;
    logic            co;
    logic [1:0]      fsm_state;

    modport master (
        output in_state, in_valid, inverse, out_ready,
        input  in_ready, out_state, out_valid, co, fsm_state
    );

    modport slave (
        input  in_state, in_valid, inverse, out_ready,
        output in_ready, out_state, out_valid, co, fsm_state
    );
endinterface

// File: rtl/rho_rotator_seq.sv
// Sequential Keccak rho step: rotates LPC lanes per cycle from a captured source
// state into a result buffer, forward (rotate left) or inverse (rotate right).
module rho_rotator_seq #(
    parameter int W   = 64,
    parameter int LPC = 1
) (
    input logic              clk,
    input logic              rst,
    rho_rotator_seq_if.slave bus
);
    localparam int         N    = 25 * W;
    localparam logic [4:0] LAST = 5'(25 - LPC);
    localparam logic [4:0] STEP = 5'(LPC);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ROT  = 2'd1,
        HOLD = 2'd2
    } state_t;

    function automatic int rho_of(input int i);
        case (i)
            0: return 21;   1: return 8;    2: return 41;   3: return 45;   4: return 15;
            5: return 56;   6: return 14;   7: return 18;   8: return 2;    9: return 61;
            10: return 28;  11: return 27;  12: return 0;   13: return 1;   14: return 62;
            15: return 55;  16: return 20;  17: return 36;  18: return 44;  19: return 6;
            20: return 25;  21: return 39;  22: return 3;   23: return 10;  24: return 43;
            default: return 0;
        endcase
    endfunction

    state_t       state;
    logic [4:0]   cnt;
    logic         inv_q;
    logic         in_ready_q;
    logic         out_valid_q;
    logic         co_q;
    logic [N-1:0] src_buf;
    logic [N-1:0] res_buf;
    logic [N-1:0] rot_state;
    logic [N-1:0] grp_mask;
    logic [24:0]  lane_sel;

    // Rotations are fixed wiring per lane; only the direction is muxed.
    for (genvar i = 0; i < 25; i++) begin : g_lane
        localparam int R = rho_of(i) % W;
        assign lane_sel[i] = (5'(i) >= cnt) && (5'(i) < cnt + STEP);
        for (genvar z = 0; z < W; z++) begin : g_bit
            assign rot_state[z*25+i] = inv_q ? src_buf[((z + R) % W) * 25 + i]
                                             : src_buf[((z + W - R) % W) * 25 + i];
            assign grp_mask[z*25+i]  = lane_sel[i];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            cnt         <= '0;
            inv_q       <= 1'b0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            co_q        <= 1'b0;
            src_buf     <= '0;
            res_buf     <= '0;
        end else begin
            co_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.in_valid && in_ready_q) begin
                        src_buf    <= bus.in_state;
                        inv_q      <= bus.inverse;
                        cnt        <= '0;
                        in_ready_q <= 1'b0;
                        // With a single group the first ROT cycle is already the last.
                        co_q       <= (LAST == 5'd0);
                        state      <= ROT;
                    end
                end
                ROT: begin
                    res_buf <= (res_buf & ~grp_mask) | (rot_state & grp_mask);
                    if (cnt == LAST) begin
                        out_valid_q <= 1'b1;
                        state       <= HOLD;
                    end else begin
                        cnt  <= cnt + STEP;
                        co_q <= (cnt + STEP == LAST);
                    end
                end
                HOLD: begin
                    if (bus.out_ready) begin
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        state       <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.out_state = res_buf;
    assign bus.co        = co_q;
    assign bus.fsm_state = state;
endmodule

// File: tb/tb_rho_rotator_seq.sv
// Directed bench for rho_rotator_seq across four W/LPC configurations sharing
// one driver; expected states are built from hand-computed bit positions.
module tb_rho_rotator_seq;
    localparam int NMAX = 25 * 64;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic [NMAX-1:0] drv_state;
    logic            drv_inverse;
    logic [3:0]      drv_valid;
    logic [3:0]      drv_ready;

    rho_rotator_seq_if #(.W(64)) if_a ();
    rho_rotator_seq_if #(.W(64)) if_b ();
    rho_rotator_seq_if #(.W(8))  if_c ();
    rho_rotator_seq_if #(.W(16)) if_d ();

    rho_rotator_seq #(.W(64), .LPC(1))  dut_a (.clk(clk), .rst(rst), .bus(if_a.slave));
    rho_rotator_seq #(.W(64), .LPC(5))  dut_b (.clk(clk), .rst(rst), .bus(if_b.slave));
    rho_rotator_seq #(.W(8),  .LPC(25)) dut_c (.clk(clk), .rst(rst), .bus(if_c.slave));
    rho_rotator_seq #(.W(16), .LPC(5))  dut_d (.clk(clk), .rst(rst), .bus(if_d.slave));

    assign if_a.in_state  = drv_state;
    assign if_b.in_state  = drv_state;
    assign if_c.in_state  = drv_state[199:0];
    assign if_d.in_state  = drv_state[399:0];
    assign if_a.in_valid  = drv_valid[0];
    assign if_b.in_valid  = drv_valid[1];
    assign if_c.in_valid  = drv_valid[2];
    assign if_d.in_valid  = drv_valid[3];
    assign if_a.out_ready = drv_ready[0];
    assign if_b.out_ready = drv_ready[1];
    assign if_c.out_ready = drv_ready[2];
    assign if_d.out_ready = drv_ready[3];
    assign if_a.inverse   = drv_inverse;
    assign if_b.inverse   = drv_inverse;
    assign if_c.inverse   = drv_inverse;
    assign if_d.inverse   = drv_inverse;

    int              sel;
    logic [NMAX-1:0] obs_state;
    logic            obs_in_ready;
    logic            obs_out_valid;
    logic            obs_co;
    logic [1:0]      obs_fsm;

    always_comb begin
        obs_state     = '0;
        obs_in_ready  = 1'b0;
        obs_out_valid = 1'b0;
        obs_co        = 1'b0;
        obs_fsm       = 2'd3;
        case (sel)
            0: begin
                obs_state = if_a.out_state; obs_in_ready = if_a.in_ready;
                obs_out_valid = if_a.out_valid; obs_co = if_a.co; obs_fsm = if_a.fsm_state;
            end
            1: begin
                obs_state = if_b.out_state; obs_in_ready = if_b.in_ready;
                obs_out_valid = if_b.out_valid; obs_co = if_b.co; obs_fsm = if_b.fsm_state;
            end
            2: begin
                obs_state = {{(NMAX-200){1'b0}}, if_c.out_state}; obs_in_ready = if_c.in_ready;
                obs_out_valid = if_c.out_valid; obs_co = if_c.co; obs_fsm = if_c.fsm_state;
            end
            3: begin
                obs_state = {{(NMAX-400){1'b0}}, if_d.out_state}; obs_in_ready = if_d.in_ready;
                obs_out_valid = if_d.out_valid; obs_co = if_d.co; obs_fsm = if_d.fsm_state;
            end
            default: ;
        endcase
    end

    int n_assert = 0;
    int n_fail   = 0;

    // ---------------- scoreboard checks ----------------
    task automatic check_vec(input string tag, input logic [NMAX-1:0] obs, input logic [NMAX-1:0] exp);
        int fb;
        fb = 0;
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            for (int b = NMAX - 1; b >= 0; b--) if (obs[b] !== exp[b]) fb = b;
            $error("FAIL %s: first differing bit %0d (lane %0d z %0d) observed %b expected %b",
                   tag, fb, fb % 25, fb / 25, obs[fb], exp[fb]);
        end
    endtask

    task automatic check_bit(input string tag, input logic obs, input logic exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic check_int(input string tag, input int obs, input int exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // ---------------- stimulus builders ----------------
    function automatic logic [NMAX-1:0] one_hot(input int lane, input int z);
        logic [NMAX-1:0] v;
        v = '0;
        v[z*25+lane] = 1'b1;
        return v;
    endfunction

    function automatic logic [NMAX-1:0] lane_val(input int lane, input logic [63:0] val, input int w);
        logic [NMAX-1:0] v;
        v = '0;
        for (int z = 0; z < w; z++) v[z*25+lane] = val[z];
        return v;
    endfunction

    // ---------------- driver tasks (entered and left at posedge + 1) ----------------
    task automatic select(input int k);
        sel = k;
        #1;
    endtask

    task automatic release_out(input string tag);
        drv_ready[sel] = 1'b1;
        @(posedge clk); #1;
        drv_ready[sel] = 1'b0;
        check_bit({tag, " out_valid after release"}, obs_out_valid, 1'b0);
        check_bit({tag, " in_ready after release"}, obs_in_ready, 1'b1);
    endtask

    task automatic run(input string tag, input logic [NMAX-1:0] st, input logic inv,
                       input int exp_lat, input bit do_release, output logic [NMAX-1:0] res);
        int waited, lat, co_at, co_cnt;
        waited = 0; lat = -1; co_at = -1; co_cnt = 0;
        drv_state = st;
        drv_inverse = inv;
        drv_valid[sel] = 1'b1;
        while (obs_in_ready !== 1'b1 && waited < 50) begin
            @(posedge clk); #1;
            waited++;
        end
        check_bit({tag, " in_ready before accept"}, obs_in_ready, 1'b1);
        @(posedge clk); #1;
        // Scramble the inputs right after accept; the state in flight must not see it.
        drv_valid[sel] = 1'b0;
        drv_state = ~st;
        drv_inverse = ~inv;
        if (obs_co === 1'b1) begin co_cnt++; co_at = 0; end
        for (int c = 1; c <= 100 && lat < 0; c++) begin
            @(posedge clk); #1;
            if (obs_co === 1'b1) begin co_cnt++; co_at = c; end
            if (obs_out_valid === 1'b1) lat = c;
        end
        res = obs_state;
        check_int({tag, " latency"}, lat, exp_lat);
        check_int({tag, " co cycle"}, co_at, exp_lat - 1);
        check_int({tag, " co count"}, co_cnt, 1);
        if (do_release) release_out(tag);
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        logic [NMAX-1:0] res, x, y, st, ex, m;
        int co_seen, ov_seen;

        rst = 1'b1; drv_state = '0; drv_inverse = 1'b0; drv_valid = '0; drv_ready = '0; sel = 0;
        repeat (2) @(posedge clk);
        #1;
        for (int k = 0; k < 4; k++) begin
            select(k);
            check_bit("reset in_ready", obs_in_ready, 1'b1);
            check_bit("reset out_valid", obs_out_valid, 1'b0);
            check_bit("reset co", obs_co, 1'b0);
            check_vec("reset out_state", obs_state, '0);
            check_int("reset fsm", int'(obs_fsm), 0);
        end
        rst = 1'b0;
        @(posedge clk); #1;

        // W=64 LPC=1: lane 0 offset 21
        select(0);
        run("w64l1 lane0", one_hot(0, 0), 1'b0, 25, 1'b1, res);
        check_vec("w64l1 lane0 result", res, one_hot(0, 21));

        // Reset in the middle of ROT with the counter at 12
        drv_state = one_hot(5, 3); drv_valid[0] = 1'b1;
        check_bit("abort in_ready before accept", obs_in_ready, 1'b1);
        @(posedge clk); #1;
        drv_valid[0] = 1'b0;
        co_seen = 0; ov_seen = 0;
        repeat (12) begin
            @(posedge clk); #1;
            if (obs_co === 1'b1) co_seen++;
        end
        check_int("abort fsm before reset", int'(obs_fsm), 1);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check_bit("abort in_ready", obs_in_ready, 1'b1);
        check_bit("abort out_valid", obs_out_valid, 1'b0);
        check_bit("abort co", obs_co, 1'b0);
        check_vec("abort out_state", obs_state, '0);
        check_int("abort fsm", int'(obs_fsm), 0);
        repeat (30) begin
            @(posedge clk); #1;
            if (obs_co === 1'b1) co_seen++;
            if (obs_out_valid === 1'b1) ov_seen++;
        end
        check_int("abort co pulses", co_seen, 0);
        check_int("abort out_valid cycles", ov_seen, 0);

        // Fresh input after the abort: lane 24 offset 43
        run("w64l1 lane24", one_hot(24, 0), 1'b0, 25, 1'b1, res);
        check_vec("w64l1 lane24 result", res, one_hot(24, 43));

        // W=64 LPC=5: random round trip, lane 12 passes through
        select(1);
        x = '0;
        for (int k = 0; k < 50; k++) x[k*32 +: 32] = $urandom();
        m = lane_val(12, 64'hFFFF_FFFF_FFFF_FFFF, 64);
        run("w64l5 fwd", x, 1'b0, 5, 1'b1, y);
        check_vec("w64l5 fwd lane12", y & m, x & m);
        run("w64l5 inv", y, 1'b1, 5, 1'b1, res);
        check_vec("w64l5 round trip", res, x);
        // lane 9 offset 61 rotated right: bit 0 lands on z = 3
        run("w64l5 inv lane9", one_hot(9, 0), 1'b1, 5, 1'b1, res);
        check_vec("w64l5 inv lane9 result", res, one_hot(9, 3));

        // Back-pressure: lane 1 offset 8 held in HOLD for 10 cycles
        run("bp", one_hot(1, 0), 1'b0, 5, 1'b0, res);
        check_vec("bp result", res, one_hot(1, 8));
        for (int k = 0; k < 10; k++) begin
            drv_valid[1] = 1'b1;
            drv_state = {$urandom(), $urandom(), $urandom(), $urandom()};
            drv_inverse = k[0];
            @(posedge clk); #1;
            check_vec("bp out_state stable", obs_state, one_hot(1, 8));
            check_bit("bp in_ready", obs_in_ready, 1'b0);
            check_bit("bp out_valid", obs_out_valid, 1'b1);
        end
        drv_valid[1] = 1'b0;
        release_out("bp");
        @(posedge clk); #1;
        check_bit("bp nothing captured", obs_out_valid, 1'b0);
        check_int("bp fsm idle", int'(obs_fsm), 0);

        // W=8 LPC=25: lane 2 offset 1, lane 12 offset 0
        select(2);
        st = one_hot(2, 0) | lane_val(12, 64'hA5, 8);
        ex = one_hot(2, 1) | lane_val(12, 64'hA5, 8);
        run("w8 fwd", st, 1'b0, 1, 1'b1, res);
        check_vec("w8 fwd result", res, ex);
        // lane 3 offset 45 mod 8 = 5 rotated right: bit 0 lands on z = 3
        run("w8 inv lane3", one_hot(3, 0), 1'b1, 1, 1'b1, res);
        check_vec("w8 inv lane3 result", res, one_hot(3, 3));

        // W=16 LPC=5: all ones, zero-offset lane, walk on lane 8 (offset 2)
        select(3);
        st = '0;
        st[399:0] = '1;
        run("w16 ones", st, 1'b0, 5, 1'b1, res);
        check_vec("w16 ones result", res, st);
        run("w16 lane12", lane_val(12, 64'hC3A5, 16), 1'b0, 5, 1'b1, res);
        check_vec("w16 lane12 result", res, lane_val(12, 64'hC3A5, 16));
        for (int z = 0; z < 16; z++) begin
            run("w16 walk", one_hot(8, z), 1'b0, 5, 1'b1, res);
            check_vec("w16 walk result", res, one_hot(8, (z + 2) % 16));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, observed no finish expected finish");
        $fatal(1, "watchdog expired");
    end
endmodule
